// File: rtl/pipelined_cpu_fwd.sv
// pipelined_cpu_fwd: 5-stage in-order 16-bit-instruction core with forwarding/interlock, EX branches and HALT
module pipelined_cpu_fwd #(
   parameter int DW     = 8,
   parameter int PCW    = 8,
   parameter int DMAW   = 8,
   parameter bit FWD_EN = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   output logic [PCW-1:0]  imem_addr,
   input  logic [15:0]     imem_rdata,
   output logic [DMAW-1:0] dmem_addr,
   output logic [DW-1:0]   dmem_wdata,
   output logic            dmem_we,
   input  logic [DW-1:0]   dmem_rdata,
   output logic [PCW-1:0]  pc,
   output logic [15:0]     instr,
   output logic            wb_we,
   output logic [1:0]      wb_addr,
   output logic [DW-1:0]   wb_data,
   output logic            stall,
   output logic            halted
);
   localparam logic [15:0] NOP = 16'h0000;
   function automatic logic wr(input logic [3:0] op);
      return op >= 4'h1 && op <= 4'h8;
   endfunction
   function automatic logic [1:0] src2(input logic [15:0] ir);
      return (ir[15:12] == 4'h9 || ir[15:12] == 4'hA) ? ir[11:10] : ir[7:6];
   endfunction
   function automatic logic dep(input logic [15:0] ir, input logic [1:0] r);
      logic [3:0] op;
      op = ir[15:12];
      return (((op >= 4'h1 && op <= 4'h5) || (op >= 4'h7 && op <= 4'hA)) && ir[9:8] == r) ||
             (((op >= 4'h1 && op <= 4'h5) || op == 4'h9 || op == 4'hA) && src2(ir) == r);
   endfunction
   logic [PCW-1:0] pc_q, pc_d, ifid_pc_q, ifid_pc_d, idex_pc_q, idex_pc_d;
   logic [15:0]    ifid_ir_q, ifid_ir_d, idex_ir_q, idex_ir_d;
   logic [DW-1:0]  idex_a_q, idex_a_d, idex_b_q, idex_b_d;
   logic [3:0]     exmem_op_q, exmem_op_d;
   logic [1:0]     exmem_rd_q, exmem_rd_d, memwb_rd_q, memwb_rd_d;
   logic [DW-1:0]  exmem_res_q, exmem_res_d, exmem_sd_q, exmem_sd_d, memwb_data_q, memwb_data_d;
   logic           memwb_we_q, memwb_we_d, memwb_halt_q, memwb_halt_d;
   logic           halted_q, halted_d, hpend_q, hpend_d;
   logic [DW-1:0]  rf_q [4];
   logic [DW-1:0]  rf_d [4];
   logic [3:0]     id_op, ex_op;
   logic [1:0]     ex_s1, ex_s2;
   logic [DW-1:0]  id_a, id_b, fa, fb, ex_res;
   logic           br_taken, hazard, fetch_stop;
   always_comb begin
      id_op = ifid_ir_q[15:12];
      ex_op = idex_ir_q[15:12];
      // regfile read with same-cycle WB bypass
      id_a = (memwb_we_q && memwb_rd_q == ifid_ir_q[9:8]) ? memwb_data_q : rf_q[ifid_ir_q[9:8]];
      id_b = (memwb_we_q && memwb_rd_q == src2(ifid_ir_q)) ? memwb_data_q : rf_q[src2(ifid_ir_q)];
      ex_s1 = idex_ir_q[9:8];
      ex_s2 = src2(idex_ir_q);
      // load data is only available from MEM/WB, so EX/MEM never forwards an LD
      fa = (FWD_EN && wr(exmem_op_q) && exmem_op_q != 4'h8 && exmem_rd_q == ex_s1) ? exmem_res_q :
           (FWD_EN && memwb_we_q && memwb_rd_q == ex_s1) ? memwb_data_q : idex_a_q;
      fb = (FWD_EN && wr(exmem_op_q) && exmem_op_q != 4'h8 && exmem_rd_q == ex_s2) ? exmem_res_q :
           (FWD_EN && memwb_we_q && memwb_rd_q == ex_s2) ? memwb_data_q : idex_b_q;
      ex_res = '0;
      case (ex_op)
         4'h1: ex_res = fa + fb;
         4'h2: ex_res = fa - fb;
         4'h3: ex_res = fa & fb;
         4'h4: ex_res = fa | fb;
         4'h5: ex_res = fa ^ fb;
         4'h6: ex_res = DW'(idex_ir_q[7:0]);
         4'h7: ex_res = fa + DW'($signed(idex_ir_q[7:0]));
         4'h8, 4'h9: ex_res = fa;
         default: ex_res = '0;
      endcase
      br_taken = ex_op == 4'hA && fa == fb;
      hazard = FWD_EN ? (ex_op == 4'h8 && dep(ifid_ir_q, idex_ir_q[11:10])) :
               ((wr(ex_op) && dep(ifid_ir_q, idex_ir_q[11:10])) || (wr(exmem_op_q) && dep(ifid_ir_q, exmem_rd_q)));
      stall = hazard && !br_taken;
      fetch_stop = hpend_q || id_op == 4'hF;
      hpend_d = hpend_q || (id_op == 4'hF && !br_taken);
      pc_d = br_taken ? idex_pc_q + PCW'(1) + PCW'($signed(idex_ir_q[7:0])) :
             (stall || fetch_stop) ? pc_q :
             id_op == 4'hB ? PCW'(ifid_ir_q[7:0]) : pc_q + PCW'(1);
      ifid_pc_d = stall ? ifid_pc_q : pc_q;
      ifid_ir_d = br_taken ? NOP : stall ? ifid_ir_q : (fetch_stop || id_op == 4'hB) ? NOP : imem_rdata;
      idex_ir_d = (br_taken || stall) ? NOP : ifid_ir_q;
      idex_pc_d = ifid_pc_q;
      idex_a_d = id_a;
      idex_b_d = id_b;
      exmem_op_d = ex_op;
      exmem_rd_d = idex_ir_q[11:10];
      exmem_res_d = ex_res;
      exmem_sd_d = fb;
      memwb_we_d = wr(exmem_op_q);
      memwb_rd_d = exmem_rd_q;
      memwb_data_d = exmem_op_q == 4'h8 ? dmem_rdata : exmem_res_q;
      memwb_halt_d = exmem_op_q == 4'hF;
      halted_d = halted_q || memwb_halt_q;
      rf_d = rf_q;
      if (memwb_we_q) rf_d[memwb_rd_q] = memwb_data_q;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q <= '0;
         ifid_pc_q <= '0;
         ifid_ir_q <= NOP;
         idex_pc_q <= '0;
         idex_ir_q <= NOP;
         idex_a_q <= '0;
         idex_b_q <= '0;
         exmem_op_q <= '0;
         exmem_rd_q <= '0;
         exmem_res_q <= '0;
         exmem_sd_q <= '0;
         memwb_we_q <= 1'b0;
         memwb_rd_q <= '0;
         memwb_data_q <= '0;
         memwb_halt_q <= 1'b0;
         halted_q <= 1'b0;
         hpend_q <= 1'b0;
         rf_q <= '{default: '0};
      end else begin
         pc_q <= pc_d;
         ifid_pc_q <= ifid_pc_d;
         ifid_ir_q <= ifid_ir_d;
         idex_pc_q <= idex_pc_d;
         idex_ir_q <= idex_ir_d;
         idex_a_q <= idex_a_d;
         idex_b_q <= idex_b_d;
         exmem_op_q <= exmem_op_d;
         exmem_rd_q <= exmem_rd_d;
         exmem_res_q <= exmem_res_d;
         exmem_sd_q <= exmem_sd_d;
         memwb_we_q <= memwb_we_d;
         memwb_rd_q <= memwb_rd_d;
         memwb_data_q <= memwb_data_d;
         memwb_halt_q <= memwb_halt_d;
         halted_q <= halted_d;
         hpend_q <= hpend_d;
         rf_q <= rf_d;
      end
   end
   assign imem_addr = pc_q;
   assign pc = ifid_pc_q;
   assign instr = ifid_ir_q;
   assign dmem_addr = DMAW'(exmem_res_q);
   assign dmem_wdata = exmem_sd_q;
   assign dmem_we = exmem_op_q == 4'h9;
   assign wb_we = memwb_we_q;
   assign wb_addr = memwb_rd_q;
   assign wb_data = memwb_data_q;
   assign halted = halted_q;
endmodule

// File: tb/tb_pipelined_cpu_fwd.sv
// tb_pipelined_cpu_fwd: runs small programs on an 8-bit forwarding core and a 16-bit interlock core against an ISA model
module tb_pipelined_cpu_fwd;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;
   logic [15:0] rom [256];
   logic [7:0]  dm8 [256];
   logic [15:0] dm16 [256];
   logic [15:0] pre [256];
   logic [7:0]  a_imem_addr, a_dmem_addr, a_dmem_wdata, a_dmem_rdata, a_pc, a_wb_data;
   logic [15:0] a_imem_rdata, a_instr;
   logic        a_dmem_we, a_wb_we, a_stall, a_halted;
   logic [1:0]  a_wb_addr;
   logic [7:0]  b_imem_addr, b_dmem_addr, b_pc;
   logic [15:0] b_imem_rdata, b_instr, b_dmem_wdata, b_dmem_rdata, b_wb_data;
   logic        b_dmem_we, b_wb_we, b_stall, b_halted;
   logic [1:0]  b_wb_addr;
   assign a_imem_rdata = rom[a_imem_addr];
   assign b_imem_rdata = rom[b_imem_addr];
   assign a_dmem_rdata = dm8[a_dmem_addr];
   assign b_dmem_rdata = dm16[b_dmem_addr];
   pipelined_cpu_fwd #(.DW(8), .PCW(8), .DMAW(8), .FWD_EN(1'b1)) dut (
      .clk(clk), .reset(reset), .imem_addr(a_imem_addr), .imem_rdata(a_imem_rdata),
      .dmem_addr(a_dmem_addr), .dmem_wdata(a_dmem_wdata), .dmem_we(a_dmem_we), .dmem_rdata(a_dmem_rdata),
      .pc(a_pc), .instr(a_instr), .wb_we(a_wb_we), .wb_addr(a_wb_addr), .wb_data(a_wb_data),
      .stall(a_stall), .halted(a_halted));
   pipelined_cpu_fwd #(.DW(16), .PCW(8), .DMAW(8), .FWD_EN(1'b0)) dut_il (
      .clk(clk), .reset(reset), .imem_addr(b_imem_addr), .imem_rdata(b_imem_rdata),
      .dmem_addr(b_dmem_addr), .dmem_wdata(b_dmem_wdata), .dmem_we(b_dmem_we), .dmem_rdata(b_dmem_rdata),
      .pc(b_pc), .instr(b_instr), .wb_we(b_wb_we), .wb_addr(b_wb_addr), .wb_data(b_wb_data),
      .stall(b_stall), .halted(b_halted));
   always @(posedge clk) begin
      if (a_dmem_we) dm8[a_dmem_addr] <= a_dmem_wdata;
      if (b_dmem_we) dm16[b_dmem_addr] <= b_dmem_wdata;
   end
   int n_vec = 0, n_err = 0;
   int st_a, st_b, we_a, we_b, ns_a, ns_b, cyc, h_id, h_up;
   logic [17:0] qa [$];
   logic [17:0] qb [$];
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic logic [15:0] rr(input logic [3:0] op, input logic [1:0] d, input logic [1:0] s, input logic [1:0] t);
      return {op, d, s, t, 6'b0};
   endfunction
   function automatic logic [15:0] ri(input logic [3:0] op, input logic [1:0] d, input logic [1:0] s, input logic [7:0] imm);
      return {op, d, s, imm};
   endfunction
   // architectural reference: executes the ROM sequentially and queues every register write
   task automatic model(input bit w16, output int nst);
      logic [15:0] r [4];
      logic [15:0] mm [256];
      logic [15:0] msk, a, b, v, sx, ir;
      logic [7:0]  p, np;
      logic [1:0]  rd;
      bit          w;
      msk = w16 ? 16'hFFFF : 16'h00FF;
      for (int i = 0; i < 4; i++) r[i] = '0;
      for (int i = 0; i < 256; i++) mm[i] = pre[i] & msk;
      p = '0;
      nst = 0;
      for (int s = 0; s < 1000; s++) begin
         ir = rom[p];
         rd = ir[11:10];
         a = r[ir[9:8]];
         b = r[ir[7:6]];
         sx = {{8{ir[7]}}, ir[7:0]};
         np = p + 8'd1;
         w = 1'b1;
         v = '0;
         if (ir[15:12] == 4'hF) break;
         case (ir[15:12])
            4'h1: v = a + b;
            4'h2: v = a - b;
            4'h3: v = a & b;
            4'h4: v = a | b;
            4'h5: v = a ^ b;
            4'h6: v = {8'h00, ir[7:0]};
            4'h7: v = a + sx;
            4'h8: v = mm[a[7:0]];
            4'h9: begin w = 1'b0; mm[a[7:0]] = r[rd]; nst++; end
            4'hA: begin w = 1'b0; if (r[rd] == a) np = p + 8'd1 + sx[7:0]; end
            4'hB: begin w = 1'b0; np = ir[7:0]; end
            default: w = 1'b0;
         endcase
         if (w) begin
            r[rd] = v & msk;
            if (w16) qb.push_back({rd, r[rd]});
            else qa.push_back({rd, r[rd]});
         end
         p = np;
      end
   endtask
   always @(negedge clk) begin
      logic [17:0] e;
      if (reset) begin
         cyc++;
         if (a_stall) st_a++;
         if (b_stall) st_b++;
         if (a_dmem_we) we_a++;
         if (b_dmem_we) we_b++;
         if (a_instr[15:12] == 4'hF && h_id < 0) h_id = cyc;
         if (a_halted && h_up < 0) h_up = cyc;
         if (a_wb_we) begin
            if (qa.size() == 0) chk("wb_a_unexpected", qa.size(), 1);
            else begin
               e = qa.pop_front();
               chk("wb_a_rd", a_wb_addr, e[17:16]);
               chk("wb_a_data", a_wb_data, e[15:0]);
            end
         end
         if (b_wb_we) begin
            if (qb.size() == 0) chk("wb_b_unexpected", qb.size(), 1);
            else begin
               e = qb.pop_front();
               chk("wb_b_rd", b_wb_addr, e[17:16]);
               chk("wb_b_data", b_wb_data, e[15:0]);
            end
         end
      end
   end
   task automatic clear();
      for (int i = 0; i < 256; i++) begin
         rom[i] = 16'h0000;
         pre[i] = '0;
         dm8[i] = '0;
         dm16[i] = '0;
      end
   endtask
   task automatic setm(input int ad, input logic [15:0] val);
      pre[ad] = val;
      dm8[ad] = val[7:0];
      dm16[ad] = val;
   endtask
   task automatic start();
      qa.delete();
      qb.delete();
      st_a = 0; st_b = 0; we_a = 0; we_b = 0; cyc = 0; h_id = -1; h_up = -1;
      model(1'b0, ns_a);
      model(1'b1, ns_b);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_imem_addr", a_imem_addr, 0);
      chk("rst_instr", a_instr, 0);
      chk("rst_wb_we", a_wb_we, 0);
      chk("rst_halted", b_halted, 0);
      reset = 1'b1;
   endtask
   task automatic finish(input string nm, input int xsa, input int xsb);
      logic [7:0] p;
      for (int c = 0; c < 400 && !(a_halted && b_halted); c++) @(negedge clk);
      chk({nm, "_halted_a"}, a_halted, 1);
      chk({nm, "_halted_b"}, b_halted, 1);
      p = a_imem_addr;
      repeat (3) @(negedge clk);
      chk({nm, "_pc_frozen"}, a_imem_addr, p);
      chk({nm, "_pending_a"}, qa.size(), 0);
      chk({nm, "_pending_b"}, qb.size(), 0);
      chk({nm, "_stores_a"}, we_a, ns_a);
      chk({nm, "_stores_b"}, we_b, ns_b);
      chk({nm, "_halt_latency"}, h_up - h_id, 4);
      if (xsa >= 0) chk({nm, "_stalls_a"}, st_a, xsa);
      if (xsb >= 0) chk({nm, "_stalls_b"}, st_b, xsb);
   endtask
   initial begin
      clear();
      rom[0] = ri(6, 1, 0, 8'd5); rom[1] = ri(6, 2, 0, 8'd3); rom[2] = rr(1, 3, 1, 2); rom[3] = 16'hF000;
      start(); finish("add", 0, 2);
      clear(); setm(4, 16'h007F);
      rom[0] = ri(6, 1, 0, 8'd4); rom[1] = ri(8, 2, 1, 8'd0); rom[2] = ri(7, 3, 2, 8'd1); rom[3] = 16'hF000;
      start(); finish("ld", 1, 4);
      clear();
      rom[0] = ri(6, 1, 0, 8'd9); rom[1] = ri(6, 2, 0, 8'd9); rom[2] = ri(4'hA, 1, 2, 8'd2);
      rom[3] = ri(6, 3, 0, 8'h11); rom[4] = ri(6, 3, 0, 8'h22); rom[5] = ri(6, 0, 0, 8'h33); rom[6] = 16'hF000;
      start(); finish("beq", 0, 2);
      clear();
      rom[0] = ri(6, 1, 0, 8'hFF); rom[1] = ri(7, 2, 1, 8'hFF); rom[2] = ri(7, 3, 1, 8'h01); rom[3] = 16'hF000;
      start(); finish("ext", 0, 2);
      clear();
      rom[0] = ri(6, 1, 0, 8'h10); rom[1] = ri(6, 3, 0, 8'hA5); rom[2] = ri(9, 3, 1, 8'd0); rom[3] = 16'hF000;
      start(); finish("st", 0, 2);
      chk("st_mem_a", dm8[16], 8'hA5);
      chk("st_mem_b", dm16[16], 16'h00A5);
      clear();
      rom[0] = ri(6, 0, 0, 8'd1); rom[1] = ri(4'hB, 0, 0, 8'd4); rom[2] = ri(6, 1, 0, 8'h55); rom[3] = ri(6, 1, 0, 8'h66);
      rom[4] = ri(6, 2, 0, 8'd7); rom[5] = ri(4'hA, 0, 2, 8'hFE); rom[6] = rr(1, 3, 0, 2); rom[7] = 16'hF000;
      start(); finish("jmp", 0, 2);
      clear();
      rom[0] = ri(6, 1, 0, 8'd1); rom[1] = ri(6, 2, 0, 8'd2); rom[2] = rr(1, 3, 1, 2); rom[3] = rr(1, 3, 3, 1);
      rom[4] = rr(1, 3, 3, 2); rom[5] = rr(1, 0, 3, 3); rom[6] = 16'hF000;
      start();
      repeat (6) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("mid_rst_imem_addr", a_imem_addr, 0);
      chk("mid_rst_pc", a_pc, 0);
      chk("mid_rst_instr", a_instr, 0);
      chk("mid_rst_wb_we", a_wb_we, 0);
      chk("mid_rst_wb_data", a_wb_data, 0);
      chk("mid_rst_stall", b_stall, 0);
      chk("mid_rst_b_wb_data", b_wb_data, 0);
      chk("mid_rst_b_instr", b_instr, 0);
      @(negedge clk);
      start(); finish("restart", 0, 8);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
